karatsuba_mult_pipe: RTL and testbench
======================================

// Module: karatsuba_mult_pipe
// PURPOSE
//   Parametrised, pipelined one-level Karatsuba multiplier for the FPU mantissa/integer datapath.
//   Splits WIDTH-bit operands into halves, forms Z0/Z1/Z2 sub-products in registered stages and recombines them.
//   Supports a per-transaction signed/unsigned mode, a valid/ready handshake on both sides and a passthrough tag.
//   Issues one result per clock when not back-pressured.
// PARAMETERS
//   WIDTH    32  operand width; even, >= 4; H = WIDTH/2
//   TAG_W    4   width of the user tag carried alongside each operation
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          operand beat valid
//   in_ready   out  1          block accepts a beat this cycle
//   in_a       in   WIDTH      multiplicand
//   in_b       in   WIDTH      multiplier
//   in_signed  in   1          1: two's-complement operands/result; 0: unsigned
//   in_tag     in   TAG_W      opaque tag, returned with the result
//   out_valid  out  1          result valid
//   out_ready  in   1          downstream accepts the result
//   out_p      out  2*WIDTH    full-precision product
//   out_tag    out  TAG_W      tag of this result
// BEHAVIOUR
//   Reset: out_valid=0, out_p=0, out_tag=0, all stage valids=0; in_ready=1 in the first cycle after reset.
//   Handshake: transfer on in_valid&in_ready / out_valid&out_ready; out_p/out_tag hold stable while out_valid&!out_ready.
//   Stall: adv = !out_valid | out_ready; in_ready = adv; every stage register advances only when adv=1.
//     Whole-pipe stall: bubbles are not squeezed out while stalled.
//   Pipeline, latency 3 cycles from accept to out_valid (full throughput when out_ready=1):
//     S1: if in_signed, take magnitudes |a|, |b| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)).
//         Record neg = in_signed & (a_msb ^ b_msb). Split into aH/aL, bH/bL.
//         Form sa = aH+aL and sb = bH+bL, each H+1 bits, no truncation.
//     S2: Z0 = aL*bL (2H), Z2 = aH*bH (2H), Z1 = sa*sb (2H+2 bits) -- registered.
//     S3: mid = Z1 - Z2 - Z0 (always >= 0, 2H+2 bits); mag = (Z2<<WIDTH) + (mid<<H) + Z0, computed in 2*WIDTH bits.
//         out_p = neg ? -mag : mag (two's complement, 2*WIDTH bits).
//   Stage valid bits travel with data; in_signed, neg and tag are pipelined alongside the data.
//   Zero operand: the result is 0 regardless of sign; neg must not produce -0 artefacts (-0 == 0 in two's complement).
//   Result is exact for all operand pairs in both modes; no overflow or saturation is possible.
//   Reset mid-operation: all in-flight beats are discarded, with no output for them; the pipe is usable the cycle after rst falls.
//   Simultaneous output pop and input push in the same cycle: both transfers occur and occupancy is unchanged.
//   in_valid=0 while adv=1 inserts a bubble (stage valid=0); data regs may update but out_valid stays 0.
// TESTING
//   Run all tests with WIDTH=16 and again at the default WIDTH=32; compare every result against the behavioural a*b.
//   T1 unsigned: a=0xFFFF, b=0xFFFF, signed=0 -> out_p=0xFFFE0001, 3 cycles after accept, tag echoed.
//   T2 signed corners: (0x8000,0x8000) -> 0x40000000; (0xFFFF,0x0001) -> 0xFFFFFFFF; (0x8000,0x7FFF) -> 0xC0008000.
//   T3 streaming: 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, tags match.
//   T4 backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and out_p/out_tag stable.
//      Release -> 3 queued results emerge in order, nothing lost or duplicated.
//   T5 reset mid-flight: assert rst with 3 beats in flight -> out_valid=0 next cycle and no stale result ever emerges.
//      A new beat (3x5, unsigned) -> 15 after 3 cycles.
//   T6 carry path: a=0x00FF_FF00, b=0xFFFF_00FF (WIDTH=32, unsigned) exercises the (H+1)-bit sums -> matches the reference product.

Source files
------------

// File: rtl/karatsuba_mult_pipe.sv
// Pipelined one-level Karatsuba multiplier, signed/unsigned per beat.
// Ports: clk, rst (sync, high); in_valid/in_ready, in_a, in_b,
//   in_signed, in_tag; out_valid/out_ready, out_p (2*WIDTH), out_tag.
// Three register stages: S1 magnitudes+half sums, S2 sub-products,
// S3 recombine+sign. Whole pipe stalls on back-pressure.
module karatsuba_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H   = WIDTH / 2;
  localparam int W2  = 2 * WIDTH;
  localparam int ZW  = 2 * H;
  localparam int Z1W = 2 * H + 2;

  logic w_adv;

  // S1 combinational
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg;
  logic [H:0]       w_sa;
  logic [H:0]       w_sb;

  // S1 registers
  logic             r1_v;
  logic             r1_neg;
  logic [TAG_W-1:0] r1_tag;
  logic [H-1:0]     r1_al;
  logic [H-1:0]     r1_ah;
  logic [H-1:0]     r1_bl;
  logic [H-1:0]     r1_bh;
  logic [H:0]       r1_sa;
  logic [H:0]       r1_sb;

  // S2 combinational / registers
  logic [ZW-1:0]    w_z0;
  logic [ZW-1:0]    w_z2;
  logic [Z1W-1:0]   w_z1;
  logic             r2_v;
  logic             r2_neg;
  logic [TAG_W-1:0] r2_tag;
  logic [ZW-1:0]    r2_z0;
  logic [ZW-1:0]    r2_z2;
  logic [Z1W-1:0]   r2_z1;

  // S3 combinational / registers
  logic [Z1W-1:0]   w_mid;
  logic [W2-1:0]    w_mag;
  logic [W2-1:0]    w_p;
  logic             r3_v;
  logic [W2-1:0]    r3_p;
  logic [TAG_W-1:0] r3_tag;

  assign w_adv     = !r3_v || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r3_v;
  assign out_p     = r3_p;
  assign out_tag   = r3_tag;

  // Negating the most negative value wraps to 2^(WIDTH-1),
  // which is the correct unsigned magnitude.
  assign w_a_neg = in_signed & in_a[WIDTH-1];
  assign w_b_neg = in_signed & in_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign w_b_mag = w_b_neg ? (~in_b + WIDTH'(1)) : in_b;
  assign w_neg   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

  assign w_sa = {1'b0, w_a_mag[WIDTH-1:H]} + {1'b0, w_a_mag[H-1:0]};
  assign w_sb = {1'b0, w_b_mag[WIDTH-1:H]} + {1'b0, w_b_mag[H-1:0]};

  assign w_z0 = {{H{1'b0}}, r1_al} * {{H{1'b0}}, r1_bl};
  assign w_z2 = {{H{1'b0}}, r1_ah} * {{H{1'b0}}, r1_bh};
  assign w_z1 = {{(H+1){1'b0}}, r1_sa} * {{(H+1){1'b0}}, r1_sb};

  // Z1 >= Z0 + Z2 always, so mid never underflows.
  assign w_mid = r2_z1 - {2'b00, r2_z2} - {2'b00, r2_z0};

  assign w_mag = {r2_z2, {WIDTH{1'b0}}}
               + ({{(W2-Z1W){1'b0}}, w_mid} << H)
               + {{WIDTH{1'b0}}, r2_z0};

  // A zero magnitude negates to zero, so no -0 artefact.
  assign w_p = r2_neg ? (~w_mag + W2'(1)) : w_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v   <= 1'b0;
      r1_neg <= 1'b0;
      r1_tag <= '0;
      r1_al  <= '0;
      r1_ah  <= '0;
      r1_bl  <= '0;
      r1_bh  <= '0;
      r1_sa  <= '0;
      r1_sb  <= '0;
    end else if (w_adv) begin
      r1_v   <= in_valid;
      r1_neg <= w_neg;
      r1_tag <= in_tag;
      r1_al  <= w_a_mag[H-1:0];
      r1_ah  <= w_a_mag[WIDTH-1:H];
      r1_bl  <= w_b_mag[H-1:0];
      r1_bh  <= w_b_mag[WIDTH-1:H];
      r1_sa  <= w_sa;
      r1_sb  <= w_sb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_v   <= 1'b0;
      r2_neg <= 1'b0;
      r2_tag <= '0;
      r2_z0  <= '0;
      r2_z2  <= '0;
      r2_z1  <= '0;
    end else if (w_adv) begin
      r2_v   <= r1_v;
      r2_neg <= r1_neg;
      r2_tag <= r1_tag;
      r2_z0  <= w_z0;
      r2_z2  <= w_z2;
      r2_z1  <= w_z1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r3_v   <= 1'b0;
      r3_p   <= '0;
      r3_tag <= '0;
    end else if (w_adv) begin
      r3_v   <= r2_v;
      r3_p   <= w_p;
      r3_tag <= r2_tag;
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Bench for karatsuba_mult_pipe: WIDTH=16 and WIDTH=32 instances
// share handshake/tag stimulus; a queue model holds a*b per beat.
module tb_karatsuba_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sgn = 1'b0;
  logic [3:0]  tag = 4'h0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;

  logic        rdy16, rdy32, v16, v32;
  logic [31:0] p16;
  logic [63:0] p32;
  logic [3:0]  t16, t32;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] e16;
    logic [63:0] e32;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  karatsuba_mult_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy16),
    .in_a(a16), .in_b(b16),
    .in_signed(sgn), .in_tag(tag),
    .out_valid(v16), .out_ready(out_ready),
    .out_p(p16), .out_tag(t16)
  );

  karatsuba_mult_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_a(a32), .in_b(b32),
    .in_signed(sgn), .in_tag(tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_p(p32), .out_tag(t32)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic s);
    logic [31:0] ea, eb;
    ea = s ? {{16{a[15]}}, a} : {16'b0, a};
    eb = s ? {{16{b[15]}}, b} : {16'b0, b};
    return ea * eb;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("valid_match", {63'b0, v16}, {63'b0, v32});
      if (v32 && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {63'b0, v32}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_pop++;
          chk("tag32", {60'b0, t32}, {60'b0, e.tag});
          chk("tag16", {60'b0, t16}, {60'b0, e.tag});
          chk("p32", p32, e.e32);
          chk("p16", {32'b0, p16}, {32'b0, e.e16});
        end
      end
      if (in_valid && rdy32) begin
        exp_t n;
        n.tag = tag;
        n.e16 = ref16(a16, b16, sgn);
        n.e32 = ref32(a32, b32, sgn);
        q.push_back(n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] c, input logic [15:0] d,
                        input logic s, input logic [3:0] t);
    a32 = a; b32 = b; a16 = c; b16 = d; sgn = s; tag = t;
  endtask

  task automatic set_rnd();
    a32 = $urandom; b32 = $urandom;
    a16 = 16'($urandom); b16 = 16'($urandom);
    sgn = 1'($urandom); tag = 4'($urandom);
    case ($urandom_range(0, 7))
      0: begin a32 = 32'h8000_0000; a16 = 16'h8000; end
      1: begin b32 = 32'h0; b16 = 16'h0; end
      2: begin a32 = 32'hFFFF_FFFF; a16 = 16'hFFFF; end
      default: ;
    endcase
  endtask

  // Holds the beat until accepted; rr randomises out_ready meanwhile.
  task automatic beat(input bit rr);
    int n = 0;
    in_valid = 1'b1;
    if (rr) begin out_ready = 1'($urandom); #1; end
    while (!rdy32 && n < 50) begin
      tick();
      n++;
      if (rr) begin out_ready = 1'($urandom); #1; end
    end
    if (!rdy32) chk("accept_timeout", {63'b0, rdy32}, 64'd1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || v32) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int p0;
    logic [63:0] hp;
    logic [3:0]  ht;

    tick(); tick();
    rst = 1'b0;
    chk("rst_v32", {63'b0, v32}, 64'd0);
    chk("rst_v16", {63'b0, v16}, 64'd0);
    chk("rst_p32", p32, 64'd0);
    chk("rst_tag", {60'b0, t32}, 64'd0);
    chk("rst_rdy", {63'b0, rdy32}, 64'd1);

    // T1 unsigned max, with latency check
    out_ready = 1'b1;
    set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 1'b0, 4'h1);
    beat(0);
    in_valid = 1'b0;
    tick();
    chk("t1_early", {63'b0, v16}, 64'd0);
    tick();
    chk("t1_valid", {63'b0, v16}, 64'd1);
    chk("t1_p16", {32'b0, p16}, 64'hFFFE_0001);
    chk("t1_p32", p32, 64'hFFFF_FFFE_0000_0001);
    chk("t1_tag", {60'b0, t16}, 64'h1);
    drain();

    // T2 signed corners and T6 carry path
    set_op(32'h8000_0000, 32'h8000_0000, 16'h8000, 16'h8000, 1'b1, 4'h2);
    beat(0);
    set_op(32'hFFFF_FFFF, 32'h1, 16'hFFFF, 16'h0001, 1'b1, 4'h3);
    beat(0);
    set_op(32'h8000_0000, 32'h7FFF_FFFF, 16'h8000, 16'h7FFF, 1'b1, 4'h4);
    beat(0);
    set_op(32'h00FF_FF00, 32'hFFFF_00FF, 16'hFF00, 16'h00FF, 1'b0, 4'h5);
    beat(0);
    set_op(32'h0, 32'h8000_0000, 16'h0, 16'hFFFF, 1'b1, 4'h6);
    beat(0);
    drain();

    // T3 streaming, full throughput
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      set_rnd();
      chk("t3_rdy", {63'b0, rdy32}, 64'd1);
      beat(0);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t3_thru", 64'(n_pop - p0), 64'd100);
    drain();

    // T4 back-pressure with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rnd();
      beat(0);
    end
    set_rnd();
    in_valid = 1'b1;
    hp = p32;
    ht = t32;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rdy", {63'b0, rdy32}, 64'd0);
      chk("t4_v", {63'b0, v32}, 64'd1);
      chk("t4_p", p32, hp);
      chk("t4_tag", {60'b0, t32}, {60'b0, ht});
      tick();
    end
    out_ready = 1'b1;
    tick();
    drain();

    // Random traffic with random back-pressure and bubbles
    for (int i = 0; i < 150; i++) begin
      set_rnd();
      beat(1);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    drain();

    // T5 reset with beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rnd();
      beat(0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_flush32", {63'b0, v32}, 64'd0);
    chk("t5_flush16", {63'b0, v16}, 64'd0);
    rst = 1'b0;
    set_op(32'd3, 32'd5, 16'd3, 16'd5, 1'b0, 4'h9);
    beat(0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("t5_valid", {63'b0, v32}, 64'd1);
    chk("t5_p32", p32, 64'd15);
    chk("t5_p16", {32'b0, p16}, 64'd15);
    drain();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
